// File: rtl/exec_step_controller.sv
// rtl/exec_step_controller.sv - run/halt/single-step sequencer for the single-cycle MIPS datapath
//
// Debounces the run and step push buttons and drives cpu_en, the commit enable
// for the PC register, register-file write and data-memory write. One cpu_en
// cycle retires exactly one instruction. RUN stops in front of a BREAK
// instruction (opcode 0, funct 0x0D); resuming commits that BREAK once.
//
// Optional feature macro: HW_BREAKPOINT_EN adds bp_addr and also stops RUN when
// pc == bp_addr.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   btn_run      raw run/stop button (asynchronous, active-high)
//   btn_step     raw single-step button (asynchronous, active-high)
//   pc           current PC from the datapath
//   instr        instruction at pc (combinational imem read)
//   bp_addr      breakpoint address (HW_BREAKPOINT_EN only)
//   cpu_en       commit enable to the datapath
//   halted       1 in HALT or BRK
//   state        00 HALT, 01 RUN, 10 STEP, 11 BRK
//   retire_count instructions committed since reset, wraps

module exec_step_controller #(
    parameter int DB_COUNT = 50000,
    parameter int DB_W     = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic [31:0]      pc,
    input  logic [31:0]      instr,
`ifdef HW_BREAKPOINT_EN
    input  logic [31:0]      bp_addr,
`endif
    output logic             cpu_en,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] retire_count
);

    localparam logic [1:0] S_HALT = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_STEP = 2'b10;
    localparam logic [1:0] S_BRK  = 2'b11;

    localparam int BTN_RUN  = 0;
    localparam int BTN_STEP = 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_COUNT - 1);

    // Button path: index 0 = run, index 1 = step.
    logic [1:0]      raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      level;
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      press;

    assign raw = {btn_step, btn_run};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
            level <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= ~level[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // The pulse is the decode of the upcoming 0->1 flip, so the FSM acts on the
    // same edge that updates the accepted level. Release flips never pulse.
    always_comb begin
        press = 2'b00;
        for (int i = 0; i < 2; i++) begin
            press[i] = sync2[i] && !level[i] && (db_cnt[i] == DB_LAST);
        end
    end

    logic run_p;
    logic step_p;

    assign run_p  = press[BTN_RUN];
    assign step_p = press[BTN_STEP];

    // Break detection. skip masks the stop for the first RUN cycle after a
    // resume so the instruction we stopped in front of is committed once.
    logic skip;
    logic is_break;
    logic brk_hit;

    assign is_break = (instr[31:26] == 6'd0) && (instr[5:0] == 6'h0D);

`ifdef HW_BREAKPOINT_EN
    assign brk_hit = (is_break || (pc == bp_addr)) && !skip;

    logic unused_instr;
    assign unused_instr = ^instr[25:6];
`else
    assign brk_hit = is_break && !skip;

    logic unused_inputs;
    assign unused_inputs = ^{instr[25:6], pc};
`endif

    logic [1:0] next_state;
    logic       next_skip;

    always_comb begin
        next_state = state;
        next_skip  = skip;
        cpu_en     = 1'b0;
        case (state)
            S_HALT: begin
                if (run_p) begin
                    next_state = S_RUN;
                end else if (step_p) begin
                    next_state = S_STEP;
                end
            end
            S_RUN: begin
                cpu_en    = !brk_hit;
                next_skip = 1'b0;
                if (run_p) begin
                    next_state = S_HALT;
                end else if (brk_hit) begin
                    next_state = S_BRK;
                end
            end
            S_STEP: begin
                cpu_en     = 1'b1;
                next_state = S_HALT;
            end
            S_BRK: begin
                if (run_p) begin
                    next_state = S_RUN;
                    next_skip  = 1'b1;
                end else if (step_p) begin
                    next_state = S_STEP;
                end
            end
            default: begin
                next_state = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_HALT;
            skip         <= 1'b0;
            retire_count <= '0;
        end else begin
            state        <= next_state;
            skip         <= next_skip;
            retire_count <= retire_count + {{(CNT_W-1){1'b0}}, cpu_en};
        end
    end

    assign halted = (state == S_HALT) || (state == S_BRK);

endmodule

// File: tb/tb_exec_step_controller.sv
// tb/tb_exec_step_controller.sv - self-checking bench for exec_step_controller

module tb_exec_step_controller;

    localparam int DB = 4;
    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] BRK = 32'h0000_000D;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_run = 1'b0;
    logic        btn_step = 1'b0;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] bp_addr = 32'hFFFF_FF00;
    logic        cpu_en;
    logic        halted;
    logic [1:0]  state;
    logic [15:0] retire_count;

    int total = 0;
    int bad = 0;

    logic [31:0] imem [0:63];

    exec_step_controller #(.DB_COUNT(DB), .DB_W(16), .CNT_W(16)) dut (
        .clk(clk),
        .reset(reset),
        .btn_run(btn_run),
        .btn_step(btn_step),
        .pc(pc),
        .instr(instr),
`ifdef HW_BREAKPOINT_EN
        .bp_addr(bp_addr),
`endif
        .cpu_en(cpu_en),
        .halted(halted),
        .state(state),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: PC advances by 4 on every committed cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc <= 32'd0;
        else if (cpu_en) pc <= pc + 32'd4;
    end
    assign instr = imem[pc[7:2]];

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = NOP;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        btn_run = 1'b0;
        btn_step = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (state !== 2'b00 || cpu_en !== 1'b0 || halted !== 1'b1 || retire_count !== 16'd0) begin
                bad++;
                $display("FAIL reset_idle cyc %0d: state=%b cpu_en=%b halted=%b retire=%0d want 00/0/1/0",
                         i, state, cpu_en, halted, retire_count);
            end
        end
    endtask

    task automatic test_step();
        int first;
        int n;
        do_reset();
        clear_imem();
        first = -1;
        n = 0;
        btn_step = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (cpu_en === 1'b1) begin
                n++;
                if (first < 0) first = i;
            end
            if (i == 6) begin
                total++;
                if (state !== 2'b10) begin
                    bad++;
                    $display("FAIL step_state_step: got %b want 10", state);
                end
            end
            if (i == 7) begin
                total++;
                if (state !== 2'b00) begin
                    bad++;
                    $display("FAIL step_state_halt: got %b want 00", state);
                end
            end
        end
        btn_step = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cpu_en === 1'b1) n++;
        end
        total++;
        if (first != 6) begin
            bad++;
            $display("FAIL step_latency: got %0d want 6", first);
        end
        total++;
        if (n != 1) begin
            bad++;
            $display("FAIL step_en_cycles: got %0d want 1", n);
        end
        total++;
        if (retire_count !== 16'd1) begin
            bad++;
            $display("FAIL step_retire: got %0d want 1", retire_count);
        end
    endtask

    task automatic press_run(input int hold);
        btn_run = 1'b1;
        repeat (hold) @(negedge clk);
        btn_run = 1'b0;
    endtask

    task automatic test_run_break(input int k, input int m);
        logic [31:0] stop_pc;
        int waited;
        do_reset();
        clear_imem();
        imem[k] = BRK;
        imem[k + 1 + m] = BRK;
        press_run(8);
        waited = 0;
        while (state !== 2'b11 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (state !== 2'b11 || pc !== 32'(4 * k) || retire_count !== 16'(k) || cpu_en !== 1'b0 || halted !== 1'b1) begin
            bad++;
            $display("FAIL brk_stop k=%0d: state=%b pc=%0h retire=%0d en=%b halted=%b want 11/%0h/%0d/0/1",
                     k, state, pc, retire_count, cpu_en, halted, 4 * k, k);
        end
        repeat (10) @(negedge clk);
        total++;
        if (state !== 2'b11 || pc !== 32'(4 * k) || retire_count !== 16'(k)) begin
            bad++;
            $display("FAIL brk_frozen k=%0d: state=%b pc=%0h retire=%0d want 11/%0h/%0d",
                     k, state, pc, retire_count, 4 * k, k);
        end
        stop_pc = 32'(4 * (k + 1 + m));
        press_run(8);
        waited = 0;
        while (!(state === 2'b11 && pc === stop_pc) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (state !== 2'b11 || pc !== stop_pc || retire_count !== 16'(k + 1 + m)) begin
            bad++;
            $display("FAIL brk_resume k=%0d m=%0d: state=%b pc=%0h retire=%0d want 11/%0h/%0d",
                     k, m, state, pc, retire_count, stop_pc, k + 1 + m);
        end
    endtask

    task automatic test_bounce();
        int n;
        int bounces;
        do_reset();
        clear_imem();
        n = 0;
        bounces = $urandom_range(4, 2);
        for (int b = 0; b < bounces; b++) begin
            btn_step = 1'b1;
            repeat ($urandom_range(DB - 1, 1)) begin
                @(negedge clk);
                if (cpu_en === 1'b1) n++;
            end
            btn_step = 1'b0;
            repeat ($urandom_range(DB - 1, 1)) begin
                @(negedge clk);
                if (cpu_en === 1'b1) n++;
            end
        end
        btn_step = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (cpu_en === 1'b1) n++;
        end
        btn_step = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (cpu_en === 1'b1) n++;
        end
        total++;
        if (n != 1 || retire_count !== 16'd1 || state !== 2'b00) begin
            bad++;
            $display("FAIL bounce: en_cycles=%0d retire=%0d state=%b want 1/1/00", n, retire_count, state);
        end
    endtask

    task automatic test_simultaneous();
        logic seen_step;
        do_reset();
        clear_imem();
        seen_step = 1'b0;
        btn_run = 1'b1;
        btn_step = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (state === 2'b10) seen_step = 1'b1;
        end
        btn_run = 1'b0;
        btn_step = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (state === 2'b10) seen_step = 1'b1;
        end
        total++;
        if (state !== 2'b01 || seen_step !== 1'b0 || halted !== 1'b0 || cpu_en !== 1'b1) begin
            bad++;
            $display("FAIL simul_run: state=%b seen_step=%b halted=%b en=%b want 01/0/0/1",
                     state, seen_step, halted, cpu_en);
        end
        press_run(10);
        repeat (10) @(negedge clk);
        total++;
        if (state !== 2'b00 || cpu_en !== 1'b0) begin
            bad++;
            $display("FAIL simul_stop: state=%b en=%b want 00/0", state, cpu_en);
        end
    endtask

    task automatic test_reset_mid_run();
        int waited;
        do_reset();
        clear_imem();
        press_run(8);
        waited = 0;
        while (retire_count !== 16'h0123 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (retire_count !== 16'h0123 || state !== 2'b01) begin
            bad++;
            $display("FAIL midrun_reach: retire=%0h state=%b want 123/01", retire_count, state);
        end
        reset = 1'b1;
        #1;
        total++;
        if (state !== 2'b00 || cpu_en !== 1'b0 || retire_count !== 16'd0) begin
            bad++;
            $display("FAIL midrun_async: state=%b en=%b retire=%0h want 00/0/0", state, cpu_en, retire_count);
        end
        @(posedge clk);
        #1;
        total++;
        if (state !== 2'b00 || cpu_en !== 1'b0 || retire_count !== 16'd0) begin
            bad++;
            $display("FAIL midrun_edge: state=%b en=%b retire=%0h want 00/0/0", state, cpu_en, retire_count);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_held();
        int waited;
        @(negedge clk);
        reset = 1'b1;
        btn_run = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (state !== 2'b00) begin
            bad++;
            $display("FAIL held_early: state=%b want 00", state);
        end
        waited = 1;
        while (state !== 2'b01 && waited < 12) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (state !== 2'b01) begin
            bad++;
            $display("FAIL held_accept: state=%b after %0d cycles want 01", state, waited);
        end
        btn_run = 1'b0;
        do_reset();
    endtask

`ifdef HW_BREAKPOINT_EN
    task automatic test_hw_breakpoint();
        int waited;
        do_reset();
        clear_imem();
        bp_addr = 32'h0000_0008;
        press_run(8);
        waited = 0;
        while (state !== 2'b11 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (state !== 2'b11 || pc !== 32'h8 || retire_count !== 16'd2) begin
            bad++;
            $display("FAIL hw_bp: state=%b pc=%0h retire=%0d want 11/8/2", state, pc, retire_count);
        end
        bp_addr = 32'hFFFF_FF00;
    endtask
`endif

    initial begin
        clear_imem();
        test_reset();
        test_step();
        test_run_break(5, 3);
        test_run_break($urandom_range(10, 1), $urandom_range(10, 0));
        test_run_break($urandom_range(10, 1), 0);
        test_bounce();
        test_bounce();
        test_simultaneous();
        test_reset_mid_run();
        test_reset_held();
`ifdef HW_BREAKPOINT_EN
        test_hw_breakpoint();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
